ikaopll_bus_sequencer: RTL and testbench

- Host-side write scheduler for the OPLL core bus (CS_n/WR_n/A0/D).
- Buffers (address, data) register-write pairs in a small FIFO.
- Replays each pair as an address write then a data write, with the YM2413-mandated wait times counted in phiM ticks.
- Sits between a CPU/soft-sequencer and the core's i_CS_n/i_WR_n/i_A0/i_D pins, so the host never has to meter bus timing itself.

---
 rtl/ikaopll_bus_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_ikaopll_bus_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ikaopll_bus_sequencer.sv
// Host-side write scheduler for the OPLL core bus: queues (address, data) pairs and replays them with YM2413 timing.
// Optional macro IKAOPLL_BUSSEQ_ADDR_SKIP_EN skips the address phase when the address repeats.
module ikaopll_bus_sequencer #(
  parameter int FIFO_DEPTH      = 4,
  parameter int STROBE_TICKS    = 2,
  parameter int ADDR_WAIT_TICKS = 12,
  parameter int DATA_WAIT_TICKS = 84
) (
  input  logic       i_EMUCLK,
  input  logic       i_RST_n,
  input  logic       i_phiM_PCEN_n,
  input  logic       i_WVALID,
  output logic       o_WREADY,
  input  logic [7:0] i_WADDR,
  input  logic [7:0] i_WDATA,
  input  logic       i_FLUSH,
  output logic       o_CS_n,
  output logic       o_WR_n,
  output logic       o_A0,
  output logic [7:0] o_D,
  output logic       o_BUSY,
  output logic [4:0] o_LEVEL
);

  localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);
  localparam logic [7:0] STRB_M1 = 8'(STROBE_TICKS - 1);
  localparam logic [7:0] AWAIT_M1 = 8'(ADDR_WAIT_TICKS - 1);
  localparam logic [7:0] DWAIT_M1 = 8'(DATA_WAIT_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    A_SETUP = 3'd1,
    A_STRB  = 3'd2,
    A_WAIT  = 3'd3,
    D_SETUP = 3'd4,
    D_STRB  = 3'd5,
    D_WAIT  = 3'd6
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [7:0]      cnt_r, cnt_nxt_s;
  logic [7:0]      addr_mem_r [FIFO_DEPTH];
  logic [7:0]      data_mem_r [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [4:0]      level_r, level_nxt_s;
  logic            wready_r, busy_r;
  logic [7:0]      txn_addr_r, txn_data_r, txn_addr_nxt_s, txn_data_nxt_s;
  logic            cs_n_r, wr_n_r, a0_r;
  logic [7:0]      d_r;
  logic            cs_n_nxt_s, wr_n_nxt_s, a0_nxt_s;
  logic [7:0]      d_nxt_s;
  logic            tick_s, push_s, pop_s, skip_s;
  logic [7:0]      head_addr_s, head_data_s;

  assign tick_s      = ~i_phiM_PCEN_n;
  assign push_s      = i_WVALID & wready_r & ~i_FLUSH;
  assign pop_s       = tick_s & (state_r == IDLE) & (level_r != 5'd0) & ~i_FLUSH;
  assign head_addr_s = addr_mem_r[rd_ptr_r];
  assign head_data_s = data_mem_r[rd_ptr_r];

`ifdef IKAOPLL_BUSSEQ_ADDR_SKIP_EN
  logic [7:0] last_addr_r;
  logic       last_valid_r;

  assign skip_s = last_valid_r & (head_addr_s == last_addr_r);

  // Remember the address most recently sent to the core.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      last_addr_r  <= 8'd0;
      last_valid_r <= 1'b0;
    end else if (pop_s) begin
      last_addr_r  <= head_addr_s;
      last_valid_r <= 1'b1;
    end
  end
`else
  assign skip_s = 1'b0;
`endif

  // FIFO occupancy; flush wins over any coincident push.
  always_comb begin
    level_nxt_s = level_r;
    if (i_FLUSH) begin
      level_nxt_s = 5'd0;
    end else if (push_s && !pop_s) begin
      level_nxt_s = level_r + 5'd1;
    end else if (pop_s && !push_s) begin
      level_nxt_s = level_r - 5'd1;
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Next state and tick counter; the counter holds remaining ticks minus one.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (tick_s) begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            state_nxt_s = skip_s ? D_SETUP : A_SETUP;
            cnt_nxt_s   = 8'd0;
          end else begin
            cnt_nxt_s = 8'd0;
          end
        end
        A_SETUP: begin
          state_nxt_s = A_STRB;
          cnt_nxt_s   = STRB_M1;
        end
        A_STRB: begin
          if (cnt_r == 8'd0) begin
            state_nxt_s = A_WAIT;
            cnt_nxt_s   = AWAIT_M1;
          end else begin
            cnt_nxt_s = cnt_r - 8'd1;
          end
        end
        A_WAIT: begin
          if (cnt_r == 8'd0) begin
            state_nxt_s = D_SETUP;
            cnt_nxt_s   = 8'd0;
          end else begin
            cnt_nxt_s = cnt_r - 8'd1;
          end
        end
        D_SETUP: begin
          state_nxt_s = D_STRB;
          cnt_nxt_s   = STRB_M1;
        end
        D_STRB: begin
          if (cnt_r == 8'd0) begin
            state_nxt_s = D_WAIT;
            cnt_nxt_s   = DWAIT_M1;
          end else begin
            cnt_nxt_s = cnt_r - 8'd1;
          end
        end
        D_WAIT: begin
          if (cnt_r == 8'd0) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 8'd0;
          end else begin
            cnt_nxt_s = cnt_r - 8'd1;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 8'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
    end
  end

  // Bus levels decoded from the next state so the pins come straight from flops.
  always_comb begin
    txn_addr_nxt_s = pop_s ? head_addr_s : txn_addr_r;
    txn_data_nxt_s = pop_s ? head_data_s : txn_data_r;
    cs_n_nxt_s     = 1'b1;
    wr_n_nxt_s     = 1'b1;
    a0_nxt_s       = a0_r;
    d_nxt_s        = d_r;
    case (state_nxt_s)
      A_SETUP: begin cs_n_nxt_s = 1'b0; a0_nxt_s = 1'b0; d_nxt_s = txn_addr_nxt_s; end
      A_STRB:  begin cs_n_nxt_s = 1'b0; wr_n_nxt_s = 1'b0; a0_nxt_s = 1'b0; d_nxt_s = txn_addr_nxt_s; end
      A_WAIT:  begin a0_nxt_s = 1'b0; d_nxt_s = txn_addr_nxt_s; end
      D_SETUP: begin cs_n_nxt_s = 1'b0; a0_nxt_s = 1'b1; d_nxt_s = txn_data_nxt_s; end
      D_STRB:  begin cs_n_nxt_s = 1'b0; wr_n_nxt_s = 1'b0; a0_nxt_s = 1'b1; d_nxt_s = txn_data_nxt_s; end
      D_WAIT:  begin a0_nxt_s = 1'b1; d_nxt_s = txn_data_nxt_s; end
      default: begin a0_nxt_s = a0_r; d_nxt_s = d_r; end
    endcase
  end

  // Sequencer, FIFO and output registers.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= 5'd0;
      wready_r   <= 1'b1;
      busy_r     <= 1'b0;
      txn_addr_r <= 8'd0;
      txn_data_r <= 8'd0;
      cs_n_r     <= 1'b1;
      wr_n_r     <= 1'b1;
      a0_r       <= 1'b0;
      d_r        <= 8'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_mem_r[i] <= 8'd0;
        data_mem_r[i] <= 8'd0;
      end
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      level_r    <= level_nxt_s;
      wready_r   <= (level_nxt_s < DEPTH_L);
      busy_r     <= (state_nxt_s != IDLE) || (level_nxt_s != 5'd0);
      txn_addr_r <= txn_addr_nxt_s;
      txn_data_r <= txn_data_nxt_s;
      cs_n_r     <= cs_n_nxt_s;
      wr_n_r     <= wr_n_nxt_s;
      a0_r       <= a0_nxt_s;
      d_r        <= d_nxt_s;
      if (push_s) begin
        addr_mem_r[wr_ptr_r] <= i_WADDR;
        data_mem_r[wr_ptr_r] <= i_WDATA;
      end
      if (i_FLUSH) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  assign o_CS_n   = cs_n_r;
  assign o_WR_n   = wr_n_r;
  assign o_A0     = a0_r;
  assign o_D      = d_r;
  assign o_BUSY   = busy_r;
  assign o_LEVEL  = level_r;
  assign o_WREADY = wready_r;

endmodule

// File: tb/tb_ikaopll_bus_sequencer.sv
// Directed self-checking bench for ikaopll_bus_sequencer (default parameters).
module tb_ikaopll_bus_sequencer;

  localparam int S = 2, AW = 12, FULL_LEN = 102, SKIP_LEN = 87;
`ifdef IKAOPLL_BUSSEQ_ADDR_SKIP_EN
  localparam bit SKIP_ON = 1'b1;
`else
  localparam bit SKIP_ON = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, pcen_n = 1'b1;
  logic wvalid = 1'b0, flush = 1'b0;
  logic [7:0] waddr = 8'd0, wdata = 8'd0;
  logic wready, cs_n, wr_n, a0, busy;
  logic [7:0] d;
  logic [4:0] level;
  int checks = 0, passes = 0;

  // Expected-waveform model: queued entries replayed from tick 1 onward.
  int m_n, m_q;
  logic [7:0] m_a [8];
  logic [7:0] m_d [8];
  bit m_skip [8];
  logic [8:0] m_hold;

  ikaopll_bus_sequencer dut (
    .i_EMUCLK(clk), .i_RST_n(rst_n), .i_phiM_PCEN_n(pcen_n),
    .i_WVALID(wvalid), .o_WREADY(wready), .i_WADDR(waddr), .i_WDATA(wdata),
    .i_FLUSH(flush), .o_CS_n(cs_n), .o_WR_n(wr_n), .o_A0(a0), .o_D(d),
    .o_BUSY(busy), .o_LEVEL(level)
  );

  always #5 clk = ~clk;

  function automatic int len_of(input int i);
    return m_skip[i] ? SKIP_LEN : FULL_LEN;
  endfunction

  function automatic logic [10:0] exp_bus(input int k);
    int cur, o;
    logic [8:0] hold;
    hold = m_hold;
    cur = 1;
    if (k == 0) return {2'b11, hold};
    for (int i = 0; i < m_n; i++) begin
      if (k < cur) return {2'b11, hold};
      if (k < cur + len_of(i)) begin
        o = k - cur + (m_skip[i] ? 1 + S + AW : 0);
        if (o == 0) return {3'b010, m_a[i]};
        if (o <= S) return {3'b000, m_a[i]};
        if (o <= S + AW) return {3'b110, m_a[i]};
        if (o == S + AW + 1) return {3'b011, m_d[i]};
        if (o <= 2 * S + AW + 1) return {3'b001, m_d[i]};
        return {3'b111, m_d[i]};
      end
      hold = {1'b1, m_d[i]};
      cur = cur + len_of(i) + 1;
    end
    return {2'b11, hold};
  endfunction

  function automatic int exp_end();
    int cur;
    cur = 1;
    for (int i = 0; i < m_n; i++) cur = cur + len_of(i) + 1;
    return cur - 1;
  endfunction

  function automatic int exp_level(input int k);
    int cur, pops;
    cur = 1;
    pops = 0;
    for (int i = 0; i < m_n; i++) begin
      if (cur <= k) pops++;
      cur = cur + len_of(i) + 1;
    end
    return m_q - pops;
  endfunction

  task automatic step(input logic p);
    pcen_n = p;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1;
    checks++;
    if ({cs_n, wr_n, a0, d, level, busy, wready} !== {3'b110, 8'h00, 5'd0, 2'b01})
      $display("FAIL reset_state: got cs/wr/a0/d/lvl/busy/rdy=%b %b %b %h %0d %b %b want 1 1 0 00 0 0 1",
               cs_n, wr_n, a0, d, level, busy, wready);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1);
  endtask

  task automatic test_single;
    int bad, bad_k, fall;
    logic [10:0] e, got;
    m_n = 1; m_q = 1; m_a[0] = 8'h10; m_d[0] = 8'h55; m_skip[0] = 1'b0; m_hold = 9'h000;
    wvalid = 1'b1; waddr = 8'h10; wdata = 8'h55;
    step(1'b0);
    wvalid = 1'b0;
    checks++;
    if (level !== 5'd1 || busy !== 1'b1) $display("FAIL single_push: lvl=%0d busy=%b want 1 1", level, busy);
    else passes++;
    bad = 0; bad_k = -1; fall = -1; got = '0; e = '0;
    for (int k = 1; k <= 120; k++) begin
      step(1'b0);
      if ({cs_n, wr_n, a0, d} !== exp_bus(k) || busy !== (k < exp_end()) || level !== 5'(exp_level(k))) begin
        if (bad == 0) begin bad_k = k; got = {cs_n, wr_n, a0, d}; e = exp_bus(k); end
        bad++;
      end
      if (busy === 1'b0 && fall < 0) fall = k;
    end
    checks++;
    if (bad !== 0) $display("FAIL single_wave: %0d bad ticks, first k=%0d bus=%h want %h", bad, bad_k, got, e);
    else passes++;
    checks++;
    if (fall !== FULL_LEN + 1) $display("FAIL single_busy_fall: tick %0d want %0d", fall, FULL_LEN + 1);
    else passes++;
  endtask

  task automatic test_stretched;
    int bad, bad_j, fall, k;
    logic p;
    m_n = 1; m_q = 1; m_a[0] = 8'h10; m_d[0] = 8'h55; m_skip[0] = SKIP_ON; m_hold = {1'b1, 8'h55};
    wvalid = 1'b1; waddr = 8'h10; wdata = 8'h55;
    step(1'b1);
    wvalid = 1'b0;
    bad = 0; bad_j = -1; fall = -1; k = 0;
    for (int j = 1; j <= 4 * 110; j++) begin
      p = (j % 4 == 0) ? 1'b0 : 1'b1;
      step(p);
      if (!p) k++;
      if ({cs_n, wr_n, a0, d} !== exp_bus(k) || busy !== (k < exp_end())) begin
        if (bad == 0) bad_j = j;
        bad++;
      end
      if (busy === 1'b0 && fall < 0) fall = j;
    end
    checks++;
    if (bad !== 0) $display("FAIL stretch_wave: %0d bad edges, first edge %0d", bad, bad_j);
    else passes++;
    checks++;
    if (fall !== 4 * exp_end()) $display("FAIL stretch_busy_fall: edge %0d want %0d", fall, 4 * exp_end());
    else passes++;
  endtask

  task automatic test_back_to_back;
    int bad, bad_k;
    logic [4:0] rdy_hist;
    m_n = 4; m_q = 4; m_hold = {1'b1, 8'h55};
    for (int i = 0; i < 4; i++) begin
      m_a[i] = 8'(i + 1); m_d[i] = 8'(8'hA1 + i); m_skip[i] = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      wvalid = 1'b1; waddr = 8'(i + 1); wdata = 8'(8'hA1 + i);
      step(1'b1);
      rdy_hist[i] = wready;
    end
    wvalid = 1'b0;
    checks++;
    if (rdy_hist !== 5'b00111) $display("FAIL b2b_wready: history %b want 00111", rdy_hist);
    else passes++;
    checks++;
    if (level !== 5'd4) $display("FAIL b2b_level_full: %0d want 4", level);
    else passes++;
    bad = 0; bad_k = -1;
    for (int k = 1; k <= 420; k++) begin
      step(1'b0);
      if ({cs_n, wr_n, a0, d} !== exp_bus(k) || busy !== (k < exp_end()) || level !== 5'(exp_level(k))) begin
        if (bad == 0) bad_k = k;
        bad++;
      end
    end
    checks++;
    if (bad !== 0) $display("FAIL b2b_wave: %0d bad ticks, first k=%0d", bad, bad_k);
    else passes++;
    checks++;
    if (level !== 5'd0 || busy !== 1'b0) $display("FAIL b2b_drain: lvl=%0d busy=%b want 0 0", level, busy);
    else passes++;
  endtask

  task automatic test_flush;
    int bad, bad_k;
    m_n = 1; m_q = 1; m_a[0] = 8'h30; m_d[0] = 8'hB0; m_skip[0] = 1'b0; m_hold = {1'b1, 8'hA4};
    for (int i = 0; i < 3; i++) begin
      wvalid = 1'b1; waddr = 8'(8'h30 + i); wdata = 8'(8'hB0 + i);
      step(1'b1);
    end
    wvalid = 1'b0;
    checks++;
    if (level !== 5'd3) $display("FAIL flush_fill: lvl=%0d want 3", level);
    else passes++;
    bad = 0; bad_k = -1;
    for (int k = 1; k <= 200; k++) begin
      if (k == 50) begin flush = 1'b1; wvalid = 1'b1; waddr = 8'h33; wdata = 8'hB3; end
      step(1'b0);
      flush = 1'b0; wvalid = 1'b0;
      if (k == 50) begin
        checks++;
        if (level !== 5'd0 || busy !== 1'b1) $display("FAIL flush_level: lvl=%0d busy=%b want 0 1", level, busy);
        else passes++;
      end
      if ({cs_n, wr_n, a0, d} !== exp_bus(k) || busy !== (k < exp_end())) begin
        if (bad == 0) bad_k = k;
        bad++;
      end
    end
    checks++;
    if (bad !== 0) $display("FAIL flush_wave: %0d bad ticks, first k=%0d", bad, bad_k);
    else passes++;
    checks++;
    if (level !== 5'd0 || wready !== 1'b1) $display("FAIL flush_end: lvl=%0d rdy=%b want 0 1", level, wready);
    else passes++;
  endtask

  task automatic test_reset_mid;
    bit found;
    wvalid = 1'b1; waddr = 8'h40; wdata = 8'hC0;
    step(1'b0);
    waddr = 8'h41; wdata = 8'hC1;
    step(1'b0);
    wvalid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (cs_n === 1'b0 && wr_n === 1'b0 && a0 === 1'b1) found = 1'b1;
      else step(1'b0);
    end
    checks++;
    if (!found) $display("FAIL rstmid_reach_dstrb: D_STRB not seen within 300 edges");
    else passes++;
    checks++;
    if (level !== 5'd1) $display("FAIL rstmid_pre_level: lvl=%0d want 1", level);
    else passes++;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cs_n, wr_n, a0, d, level, busy, wready} !== {3'b110, 8'h00, 5'd0, 2'b01})
      $display("FAIL rstmid_async: cs/wr/a0/d/lvl/busy/rdy=%b %b %b %h %0d %b %b want 1 1 0 00 0 0 1",
               cs_n, wr_n, a0, d, level, busy, wready);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0);
    step(1'b0);
    checks++;
    if (cs_n !== 1'b1 || busy !== 1'b0 || level !== 5'd0) $display("FAIL rstmid_after: cs=%b busy=%b lvl=%0d want 1 0 0", cs_n, busy, level);
    else passes++;
  endtask

  task automatic test_addr_skip;
    int bad, bad_k, fall;
    m_n = 2; m_q = 2; m_hold = 9'h000;
    m_a[0] = 8'h20; m_d[0] = 8'h01; m_skip[0] = 1'b0;
    m_a[1] = 8'h20; m_d[1] = 8'h02; m_skip[1] = SKIP_ON;
    for (int i = 0; i < 2; i++) begin
      wvalid = 1'b1; waddr = 8'h20; wdata = 8'(i + 1);
      step(1'b1);
    end
    wvalid = 1'b0;
    bad = 0; bad_k = -1; fall = -1;
    for (int k = 1; k <= 220; k++) begin
      step(1'b0);
      if ({cs_n, wr_n, a0, d} !== exp_bus(k) || level !== 5'(exp_level(k))) begin
        if (bad == 0) bad_k = k;
        bad++;
      end
      if (busy === 1'b0 && fall < 0) fall = k;
    end
    checks++;
    if (bad !== 0) $display("FAIL skip_wave: %0d bad ticks, first k=%0d", bad, bad_k);
    else passes++;
    checks++;
    if (fall !== (SKIP_ON ? 104 + SKIP_LEN : 104 + FULL_LEN))
      $display("FAIL skip_length: busy fell at tick %0d want %0d", fall, SKIP_ON ? 104 + SKIP_LEN : 104 + FULL_LEN);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stretched();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_addr_skip();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
